dmem_arbiter: RTL and testbench

Two-requester arbiter for the single-port data memory of the MIPS processor. It shares the memory between the CPU load/store path and an auxiliary requester, such as a program/debug loader or an I/O engine. The CPU has priority. A starvation guard guarantees the auxiliary port forward progress. The block stalls the CPU when it loses a cycle, and gives the auxiliary port a req/ack handshake with registered read data.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/dmem_arb_starve_counter.sv | 34 +++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// starvation counter width and the largest legal starvation limit.
package dmem_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } arb_state_e;

   localparam int STARVE_CNT_WIDTH = 4;
   localparam int STARVE_LIMIT_MAX = 15;

endpackage

// File: rtl/dmem_arb_starve_counter.sv
// Saturating starvation counter for the aux requester. It counts cycles
// in which aux wanted the memory but lost to the CPU. The clear input
// beats the hold input, and hold beats the increment input.
module dmem_arb_starve_counter
   import dmem_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   input  logic hold,
   output logic at_limit
);

   localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT_VAL = STARVE_CNT_WIDTH'(LIMIT);

   logic [STARVE_CNT_WIDTH-1:0] count_reg;

   // Count lost cycles and stop counting at the limit.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count_reg <= '0;
      end else if (hold) begin
         count_reg <= count_reg;
      end else if (inc && (count_reg != LIMIT_VAL)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign at_limit = (count_reg == LIMIT_VAL);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory. The CPU has
// priority. The aux port gets a req/ack handshake with registered read
// data. Define DMEM_ARB_STARVE_GUARD_EN to add the starvation guard, which
// forces an aux grant after STARVE_LIMIT lost cycles. Without that macro
// the CPU has strict priority and is never stalled.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   input  logic                  aux_req,
   input  logic                  aux_we,
   input  logic [ADDR_WIDTH-1:0] aux_addr,
   input  logic [DATA_WIDTH-1:0] aux_wdata,
   output logic [DATA_WIDTH-1:0] aux_rdata,
   output logic                  aux_ack,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   arb_state_e            state_reg;
   arb_state_e            state_next;
   logic                  grant_aux;
   logic                  grant_cpu;
   logic                  force_aux;
   logic [DATA_WIDTH-1:0] aux_rdata_reg;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   logic starve_inc;
   logic starve_clr;
   logic starve_hold;

   // Count only cycles in which aux is eligible but loses. A grant or a
   // withdrawn request starts the count again.
   assign starve_inc  = aux_req && (state_reg == ST_IDLE) && !grant_aux;
   assign starve_clr  = grant_aux || !aux_req;
   assign starve_hold = (state_reg == ST_ACK);

   dmem_arb_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_counter (
      .clk      (clk),
      .reset    (reset),
      .inc      (starve_inc),
      .clr      (starve_clr),
      .hold     (starve_hold),
      .at_limit (force_aux)
   );

   assign cpu_stall = cpu_req && grant_aux;
`else
   // Strict CPU priority: aux only ever uses cycles the CPU leaves idle.
   assign force_aux = 1'b0;
   assign cpu_stall = 1'b0;
`endif

   // Next-state and grant decision. Aux is eligible only in ST_IDLE.
   always_comb begin
      state_next = state_reg;
      grant_aux  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            grant_aux = aux_req && (!cpu_req || force_aux);
            if (grant_aux) begin
               state_next = ST_ACK;
            end
         end
         ST_ACK: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign grant_cpu = cpu_req && !grant_aux;

   // Memory port mux. When there is no grant, all strobes and the bus are zero.
   always_comb begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_aux) begin
         mem_we    = aux_we;
         mem_re    = !aux_we;
         mem_addr  = aux_addr;
         mem_wdata = aux_wdata;
      end else if (grant_cpu) begin
         mem_we    = cpu_we;
         mem_re    = !cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
   end

   // State register. Reset drops any pending ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Capture aux read data on the grant edge. Aux writes leave it unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         aux_rdata_reg <= '0;
      end else if (grant_aux && !aux_we) begin
         aux_rdata_reg <= mem_rdata;
      end
   end

   // The ack pulse is simply the registered ST_ACK state.
   assign aux_ack   = (state_reg == ST_ACK);
   assign aux_rdata = aux_rdata_reg;
   assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter. A behavioural memory sits on
// the memory port. Expected aux read data is queued when a grant is seen and
// compared when aux_ack arrives. Starvation expectations follow
// DMEM_ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps
module tb_dmem_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          cpu_stall;
   logic          aux_req, aux_we;
   logic [AW-1:0] aux_addr;
   logic [DW-1:0] aux_wdata, aux_rdata;
   logic          aux_ack;
   logic          mem_we, mem_re;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] sb_q[$];
   logic [DW-1:0] last_rdata;
   logic [DW-1:0] exp_word;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .aux_req   (aux_req),
      .aux_we    (aux_we),
      .aux_addr  (aux_addr),
      .aux_wdata (aux_wdata),
      .aux_rdata (aux_rdata),
      .aux_ack   (aux_ack),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Behavioural memory: a word that was never written returns a fixed
   // initial pattern. The memory has an asynchronous read and a write on the clock edge.
   logic [DW-1:0] mem [256];
   bit            written [256];

   function automatic logic [DW-1:0] init_word(input logic [7:0] idx);
      case (idx)
         8'h04:   return 32'hDEADBEEF;
         8'h0C:   return 32'hA5A55A5A;
         default: return {24'h00C0DE, idx};
      endcase
   endfunction

   function automatic logic [DW-1:0] peek(input logic [AW-1:0] a);
      return written[a[9:2]] ? mem[a[9:2]] : init_word(a[9:2]);
   endfunction

   always_comb begin
      mem_rdata = written[mem_addr[9:2]] ? mem[mem_addr[9:2]] : init_word(mem_addr[9:2]);
   end

   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         mem[mem_addr[9:2]]     <= mem_wdata;
         written[mem_addr[9:2]] <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Record the aux read that is granted this cycle.
   task automatic push_read(input logic [AW-1:0] a);
      sb_q.push_back(peek(a));
   endtask

   // Compare the ack cycle against the oldest queued read.
   task automatic expect_read_ack(input string tag);
      check({tag, "_ack"}, aux_ack, 1'b1);
      check({tag, "_sb_nonempty"}, sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
         exp_word = sb_q.pop_front();
         check({tag, "_rdata"}, aux_rdata, exp_word);
         last_rdata = exp_word;
         $display("TXN %s aux read data=0x%08h", tag, aux_rdata);
      end
   endtask

   initial begin
      reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h10; aux_wdata = '0;
      last_rdata = '0;

      // Reset held while aux requests: no ack, data zero, no stall.
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         check("rst_ack", aux_ack, 1'b0);
         check("rst_rdata", aux_rdata, 32'h0);
         check("rst_stall", cpu_stall, 1'b0);
      end
      reset = 1'b0; #1;
      check("post_rst_mem_re", mem_re, 1'b1);
      check("post_rst_mem_addr", mem_addr, 32'h10);
      push_read(32'h10);
      tick();
      expect_read_ack("first_read");
      check("first_read_const", aux_rdata, 32'hDEADBEEF);
      aux_req = 1'b0; #1;
      check("ack_cycle_no_re", mem_re, 1'b0);
      tick();
      check("ack_one_cycle", aux_ack, 1'b0);

      // Aux write 0x20 under continuous CPU reads.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h20; aux_wdata = 32'h12345678;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      for (int i = 0; i <= LIMIT; i++) begin
         #1;
         if (i < LIMIT) begin
            check("starve_stall_lo", cpu_stall, 1'b0);
            check("starve_cpu_addr", mem_addr, 32'h40);
            check("starve_cpu_rdata", cpu_rdata, peek(32'h40));
         end else begin
            check("starve_stall_hi", cpu_stall, 1'b1);
            check("starve_aux_we", mem_we, 1'b1);
            check("starve_aux_addr", mem_addr, 32'h20);
            check("starve_aux_wdata", mem_wdata, 32'h12345678);
         end
         tick();
      end
      check("starve_write_ack", aux_ack, 1'b1);
      aux_req = 1'b0; #1;
      check("ack_cpu_not_stalled", cpu_stall, 1'b0);
      check("ack_cpu_granted", mem_re, 1'b1);
      cpu_req = 1'b0;
`else
      for (int i = 0; i < 20; i++) begin
         #1;
         check("strict_stall", cpu_stall, 1'b0);
         check("strict_no_ack", aux_ack, 1'b0);
         check("strict_cpu_addr", mem_addr, 32'h40);
         tick();
      end
      cpu_req = 1'b0; #1;
      check("strict_aux_we", mem_we, 1'b1);
      check("strict_aux_addr", mem_addr, 32'h20);
      tick();
      check("strict_write_ack", aux_ack, 1'b1);
      aux_req = 1'b0;
`endif
      check("write_keeps_rdata", aux_rdata, last_rdata);
      check("mem_0x20", peek(32'h20), 32'h12345678);
      $display("TXN aux write addr=0x20 data=0x%08h", peek(32'h20));
      tick();
      check("write_ack_one_cycle", aux_ack, 1'b0);

      // Back-to-back aux reads with the request held high.
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h10;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (i % 2 == 0) begin
            check("b2b_idle_ack", aux_ack, 1'b0);
            check("b2b_grant_re", mem_re, 1'b1);
            push_read(aux_addr);
         end else begin
            expect_read_ack("b2b");
            check("b2b_ack_no_re", mem_re, 1'b0);
            aux_addr = (aux_addr == 32'h10) ? 32'h30 : 32'h10;
         end
         tick();
      end
      aux_req = 1'b0;

      // CPU store and aux read in the same cycle: the CPU wins.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'hCAFEF00D;
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h10;
      #1;
      check("same_cyc_stall", cpu_stall, 1'b0);
      check("same_cyc_we", mem_we, 1'b1);
      check("same_cyc_addr", mem_addr, 32'h50);
      check("same_cyc_wdata", mem_wdata, 32'hCAFEF00D);
      tick();
      check("cpu_store_commit", peek(32'h50), 32'hCAFEF00D);
      $display("TXN cpu write addr=0x50 data=0x%08h", peek(32'h50));
`ifdef DMEM_ARB_STARVE_GUARD_EN
      // One cycle is already lost, so the forced grant comes LIMIT cycles later.
      cpu_we = 1'b0; cpu_addr = 32'h40;
      for (int j = 1; j <= LIMIT; j++) begin
         #1;
         check("cnt1_stall", cpu_stall, (j == LIMIT) ? 1'b1 : 1'b0);
         if (j == LIMIT) push_read(32'h10);
         tick();
      end
      cpu_req = 1'b0;
`else
      cpu_req = 1'b0; cpu_we = 1'b0; #1;
      check("after_store_re", mem_re, 1'b1);
      push_read(32'h10);
      tick();
`endif
      expect_read_ack("after_store");
      aux_req = 1'b0;
      tick();

      // Aux drops its request before a grant: no ack, and the count starts again.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      aux_req = 1'b1; aux_addr = 32'h30;
      for (int i = 0; i < 2; i++) begin
         #1; check("drop_stall", cpu_stall, 1'b0); tick();
      end
      aux_req = 1'b0;
      tick();
      check("drop_no_ack", aux_ack, 1'b0);
      aux_req = 1'b1;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      for (int i = 0; i <= LIMIT; i++) begin
         #1;
         check("drop_restart_stall", cpu_stall, (i == LIMIT) ? 1'b1 : 1'b0);
         if (i == LIMIT) push_read(32'h30);
         tick();
      end
      cpu_req = 1'b0;
`else
      for (int i = 0; i < 6; i++) begin
         #1; check("drop_strict_no_ack", aux_ack, 1'b0); tick();
      end
      cpu_req = 1'b0; #1;
      push_read(32'h30);
      tick();
`endif
      expect_read_ack("after_drop");
      aux_req = 1'b0;
      tick();

      // Reset at the grant edge: the write still reaches memory and the ack is dropped.
      reset = 1'b1; aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h60; aux_wdata = 32'h0BADF00D;
      #1;
      check("rst_grant_we", mem_we, 1'b1);
      tick();
      check("rst_ack_suppressed", aux_ack, 1'b0);
      check("rst_rdata_cleared", aux_rdata, 32'h0);
      check("rst_write_landed", peek(32'h60), 32'h0BADF00D);
      reset = 1'b0; aux_req = 1'b0; aux_we = 1'b0;
      tick();
      check("rst_no_late_ack", aux_ack, 1'b0);

      // Recovery read.
      aux_req = 1'b1; aux_addr = 32'h30; #1;
      push_read(32'h30);
      tick();
      expect_read_ack("recover");
      aux_req = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
